pipe_ctrl: RTL
==============

// Module: pipe_ctrl
// PURPOSE
//  Central pipeline controller for the 5-stage MIPS core. Merges stall requests from ID (load-use)
//  and EX, sequences the multi-cycle divider through a start/ready handshake with a watchdog,
//  and applies exception flush. Drives the per-stage stall vector into pc_reg, if_id, id_ex,
//  ex_mem and mem_wb. Keeps a saturating stall-cycle performance counter.
// PARAMETERS
//  STALL_W      6    stall vector width: bit0 pc, 1 if/id, 2 id/ex, 3 ex/mem, 4 mem/wb, 5 wb
//  DIV_TIMEOUT  40   max cycles in DIV_BUSY before annul (divider nominal latency 32-34)
//  CNT_W        6    watchdog counter width; must satisfy 2**CNT_W > DIV_TIMEOUT
//  PERF_W       32   stall-cycle counter width
// PORTS
//  clk              in   1        clock, rising edge
//  rst              in   1        reset, synchronous, active-high
//  stallreq_id_i    in   1        ID load-use hazard, hold pc/if/id
//  stallreq_ex_i    in   1        EX generic multi-cycle hold (non-divide)
//  div_req_i        in   1        EX holds a divide; level, stays high until div_done_o
//  div_ready_i      in   1        divider result valid, 1-cycle pulse
//  flush_i          in   1        exception/ERET flush request, 1-cycle pulse
//  stall_o          out  STALL_W  per-stage stall vector
//  flush_o          out  1        clear all pipeline registers this cycle
//  div_start_o      out  1        start divider, 1-cycle pulse
//  div_annul_o      out  1        abort divider, 1-cycle pulse
//  div_done_o       out  1        EX may consume divider result this cycle
//  div_timeout_o    out  1        sticky: a divide hit the watchdog; cleared only by rst
//  stall_cycles_o   out  PERF_W   count of cycles with stall_o != 0, saturates at all-ones
// BEHAVIOUR
//  Reset: state=IDLE; wdog=0; stall_cycles_o=0; div_timeout_o=0; all other outputs 0 (comb, follow state).
//  FSM states: IDLE, DIV_BUSY, DIV_DONE (encodings defined in defines.v).
//   IDLE:     div_req_i & !flush_i -> div_start_o=1 (comb, same cycle), wdog<=0, next DIV_BUSY.
//   DIV_BUSY: wdog++ per cycle. div_ready_i -> DIV_DONE. Else wdog==DIV_TIMEOUT-1 -> div_annul_o=1,
//             div_timeout_o<=1, next DIV_DONE (EX gets div_done_o with whatever result; no retry).
//   DIV_DONE: div_done_o=1 for exactly one cycle, EX stall released so the divide retires; next IDLE.
//             A back-to-back divide is seen in IDLE next cycle -> start 1 cycle later (1 bubble).
//  flush_i (any state, highest priority): flush_o=1, stall_o=0, next IDLE; if state==DIV_BUSY,
//   div_annul_o=1 same cycle; div_start_o and div_done_o forced 0. div_ready_i coincident with flush ignored.
//  div_ready_i in IDLE/DIV_DONE ignored. div_ready_i and timeout in same cycle: ready wins, no annul.
//  stall_o (combinational, priority high->low):
//   flush_i                                              -> 6'b000000
//   (IDLE & div_req_i) | DIV_BUSY | stallreq_ex_i       -> 6'b001111 (pc,if,id,ex held)
//   stallreq_id_i                                        -> 6'b000111
//   otherwise                                            -> 6'b000000
//   DIV_DONE does not itself stall; stallreq_ex_i/stallreq_id_i still apply there.
//  Latency: stall asserted in the same cycle as the request; divide minimum occupancy =
//   1 (IDLE start) + N (BUSY until ready) + 1 (DONE) cycles.
//  stall_cycles_o: +1 on each edge where stall_o != 0; holds at 2**PERF_W-1. Not cleared by flush.
//  Reset mid-divide: next edge returns to IDLE without div_annul_o; divider is reset by the same rst.
//  All state updates on rising clk; rst dominates every other input.
// STRUCTURE
//  defines.v: `StallBus [5:0]; stall codes `StallNone 6'b000000, `StallId 6'b000111,
//   `StallEx 6'b001111; FSM encodings `CtrlIdle, `CtrlDivBusy, `CtrlDivDone.
//  One sub-module: sat_counter (PERF_W, inc, rst) for stall_cycles_o. FSM, watchdog and the
//   stall priority mux stay inline.
//  Top-level integration: stall_o to all pipeline regs; div_* to ex and div unit; flush_o to all regs.
// TESTING
//  1 stallreq_id_i=1 for 2 cycles, no divide -> stall_o=000111 both cycles, stall_cycles_o=2.
//  2 div_req_i rises; div_ready_i pulses 33 cycles after div_start_o -> start pulse cycle 0,
//    stall_o=001111 cycles 0..33, div_done_o at cycle 34 with stall_o=0, state IDLE at 35.
//  3 div_req_i held, div_ready_i never -> div_annul_o pulse after DIV_TIMEOUT=40 BUSY cycles,
//    div_timeout_o=1 sticky, div_done_o next cycle.
//  4 flush_i at BUSY cycle 10 -> same cycle flush_o=1, div_annul_o=1, stall_o=0; IDLE next;
//    later div_ready_i produces no div_done_o.
//  5 Two divides back-to-back -> second div_start_o exactly 1 cycle after first div_done_o.
//  6 rst asserted in DIV_BUSY with stallreq_id_i=1 -> next cycle all outputs 0, counter 0,
//    div_timeout_o=0; force counter near max to confirm saturation at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and stall encodings for the pipeline controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    CTRL_IDLE,
    CTRL_DIV_BUSY,
    CTRL_DIV_DONE
  } ctrl_state_e;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/stall bundle between the pipeline stages and pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int unsigned STALL_W = 6,
  parameter int unsigned PERF_W  = 32
);
  logic               stallreq_id_i;
  logic               stallreq_ex_i;
  logic               div_req_i;
  logic               div_ready_i;
  logic               flush_i;
  logic [STALL_W-1:0] stall_o;
  logic               flush_o;
  logic               div_start_o;
  logic               div_annul_o;
  logic               div_done_o;
  logic               div_timeout_o;
  logic [PERF_W-1:0]  stall_cycles_o;

  modport master (
    output stallreq_id_i, stallreq_ex_i, div_req_i, div_ready_i, flush_i,
    input  stall_o, flush_o, div_start_o, div_annul_o, div_done_o,
           div_timeout_o, stall_cycles_o
  );

  modport slave (
    input  stallreq_id_i, stallreq_ex_i, div_req_i, div_ready_i, flush_i,
    output stall_o, flush_o, div_start_o, div_annul_o, div_done_o,
           div_timeout_o, stall_cycles_o
  );
endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter used for the stall-cycle performance statistic.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall merge, divider sequencing with watchdog, flush.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STALL_W     = 6,
  parameter int unsigned DIV_TIMEOUT = 40,
  parameter int unsigned CNT_W       = 6,
  parameter int unsigned PERF_W      = 32
) (
  input  logic      clk,
  input  logic      rst,
  pipe_ctrl_if.slave bus
);
  ctrl_state_e state_q, state_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic timeout_q, timeout_d;
  logic [5:0] stall_code;
  logic start, annul, done;

  always_comb begin
    state_d   = state_q;
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
    start     = 1'b0;
    annul     = 1'b0;
    done      = 1'b0;
    if (bus.flush_i) begin
      // Flush overrides everything; an in-flight divide must be aborted.
      state_d = CTRL_IDLE;
      annul   = (state_q == CTRL_DIV_BUSY);
    end else begin
      unique case (state_q)
        CTRL_IDLE: begin
          if (bus.div_req_i) begin
            start   = 1'b1;
            wdog_d  = '0;
            state_d = CTRL_DIV_BUSY;
          end
        end
        CTRL_DIV_BUSY: begin
          wdog_d = wdog_q + CNT_W'(1);
          if (bus.div_ready_i) begin
            state_d = CTRL_DIV_DONE;
          end else if (wdog_q == CNT_W'(DIV_TIMEOUT - 1)) begin
            annul     = 1'b1;
            timeout_d = 1'b1;
            state_d   = CTRL_DIV_DONE;
          end
        end
        CTRL_DIV_DONE: begin
          done    = 1'b1;
          state_d = CTRL_IDLE;
        end
        default: state_d = CTRL_IDLE;
      endcase
    end
  end

  always_comb begin
    stall_code = STALL_NONE;
    if (bus.flush_i)
      stall_code = STALL_NONE;
    else if ((state_q == CTRL_IDLE && bus.div_req_i) || state_q == CTRL_DIV_BUSY ||
             bus.stallreq_ex_i)
      stall_code = STALL_EX;
    else if (bus.stallreq_id_i)
      stall_code = STALL_ID;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CTRL_IDLE;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.stall_o       = STALL_W'(stall_code);
  assign bus.flush_o       = bus.flush_i;
  assign bus.div_start_o   = start;
  assign bus.div_annul_o   = annul;
  assign bus.div_done_o    = done;
  assign bus.div_timeout_o = timeout_q;

  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (stall_code != STALL_NONE),
    .count_o (bus.stall_cycles_o)
  );
endmodule
